// File: rtl/stage2_message_framer_pkg.sv
// Shared framer definitions: FSM state encoding, error codes and header byte counts,
// kept next to the stage-3 sequence-number width they must agree with.
package stage2_message_framer_pkg;

    localparam int packet_seq_num_data_bits = 64;

    localparam int SESSION_BYTES_DEFAULT = 10;
    localparam int COUNT_BYTES           = 2;
    localparam int BYTE_CNT_W            = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SESSION = 3'd1,
        ST_SEQ     = 3'd2,
        ST_COUNT   = 3'd3,
        ST_LEN_HI  = 3'd4,
        ST_LEN_LO  = 3'd5,
        ST_PAYLOAD = 3'd6,
        ST_DROP    = 3'd7
    } fsm_state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_TRUNC = 2'd1,
        ERR_TRAIL = 2'd2,
        ERR_SOP   = 2'd3
    } err_code_e;

endpackage

// File: rtl/stage2_message_framer.sv
// Splits a byte stream of packets (session ID, sequence number, message count, then
// length-prefixed messages) into message payload bytes with header and error strobes.
module stage2_message_framer
    import stage2_message_framer_pkg::*;
#(
    parameter int SEQ_W         = packet_seq_num_data_bits,
    parameter int SESSION_BYTES = SESSION_BYTES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             msg_valid,
    output logic [7:0]       msg_data,
    output logic             msg_sop,
    output logic             msg_eop,
    output logic             message_en,
    output logic             hdr_valid,
    output logic [SEQ_W-1:0] hdr_seq_num,
    output logic [15:0]      hdr_msg_count,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output fsm_state_e       dbg_state
);

    localparam int SEQ_BYTES = SEQ_W / 8;
    localparam logic [BYTE_CNT_W-1:0] SESS_LAST  = BYTE_CNT_W'(SESSION_BYTES - 1);
    localparam logic [BYTE_CNT_W-1:0] SEQ_LAST   = BYTE_CNT_W'(SEQ_BYTES - 1);
    localparam logic [BYTE_CNT_W-1:0] COUNT_LAST = BYTE_CNT_W'(COUNT_BYTES - 1);

    fsm_state_e             state_q, state_d;
    logic [BYTE_CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEQ_W-1:0]       seq_sh_q, seq_sh_d;
    logic [15:0]            cnt_sh_q, cnt_sh_d;
    logic [15:0]            msgs_left_q, msgs_left_d;
    logic [15:0]            len_left_q, len_left_d;
    logic [7:0]             len_hi_q, len_hi_d;
    logic                   first_q, first_d;
    logic                   trail_err_q, trail_err_d;

    logic                   msg_valid_q, msg_valid_d;
    logic [7:0]             msg_data_q, msg_data_d;
    logic                   msg_sop_q, msg_sop_d;
    logic                   msg_eop_q, msg_eop_d;
    logic                   message_en_q, message_en_d;
    logic                   hdr_valid_q, hdr_valid_d;
    logic [SEQ_W-1:0]       hdr_seq_q, hdr_seq_d;
    logic [15:0]            hdr_cnt_q, hdr_cnt_d;
    logic                   err_pulse_q, err_pulse_d;
    logic [1:0]             err_code_q, err_code_d;

    logic [15:0]            full_count;
    logic [15:0]            eff_count;
    logic [15:0]            full_len;
    logic                   last_byte;
    logic                   last_msg;
    logic                   trunc;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        seq_sh_d     = seq_sh_q;
        cnt_sh_d     = cnt_sh_q;
        msgs_left_d  = msgs_left_q;
        len_left_d   = len_left_q;
        len_hi_d     = len_hi_q;
        first_d      = first_q;
        trail_err_d  = trail_err_q;
        msg_valid_d  = 1'b0;
        msg_data_d   = msg_data_q;
        msg_sop_d    = 1'b0;
        msg_eop_d    = 1'b0;
        message_en_d = 1'b0;
        hdr_valid_d  = 1'b0;
        hdr_seq_d    = hdr_seq_q;
        hdr_cnt_d    = hdr_cnt_q;
        err_pulse_d  = 1'b0;
        err_code_d   = err_code_q;
        trunc        = 1'b0;

        full_count = {cnt_sh_q[7:0], in_data};
        eff_count  = (full_count == 16'hFFFF) ? 16'h0000 : full_count;
        full_len   = {len_hi_q, in_data};
        last_byte  = (len_left_q == 16'd1);
        last_msg   = (msgs_left_q == 16'd1);

        if (in_valid) begin
            if (in_sop) begin
                // Any sop restarts parsing; mid-packet it first closes what was open.
                if (state_q != ST_IDLE) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_SOP;
                    if (state_q == ST_PAYLOAD && !first_q) begin
                        msg_eop_d = 1'b1;
                    end
                end
                seq_sh_d    = '0;
                cnt_sh_d    = '0;
                msgs_left_d = '0;
                len_left_d  = '0;
                first_d     = 1'b0;
                trail_err_d = 1'b0;
                if (in_eop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (state_q == ST_IDLE) begin
                        trunc = 1'b1;
                    end
                end else if (SESSION_BYTES > 1) begin
                    state_d = ST_SESSION;
                    cnt_d   = BYTE_CNT_W'(1);
                end else begin
                    state_d = ST_SEQ;
                    cnt_d   = '0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                    end
                    ST_SESSION: begin
                        if (cnt_q == SESS_LAST) begin
                            state_d = ST_SEQ;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        trunc = in_eop;
                    end
                    ST_SEQ: begin
                        seq_sh_d = (seq_sh_q << 8) | SEQ_W'(in_data);
                        if (cnt_q == SEQ_LAST) begin
                            state_d = ST_COUNT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        trunc = in_eop;
                    end
                    ST_COUNT: begin
                        cnt_sh_d = full_count;
                        if (cnt_q == COUNT_LAST) begin
                            hdr_valid_d = 1'b1;
                            hdr_seq_d   = seq_sh_q;
                            hdr_cnt_d   = full_count;
                            msgs_left_d = eff_count;
                            cnt_d       = '0;
                            if (eff_count != 16'd0) begin
                                state_d = ST_LEN_HI;
                                trunc   = in_eop;
                            end else begin
                                state_d = in_eop ? ST_IDLE : ST_DROP;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            trunc = in_eop;
                        end
                    end
                    ST_LEN_HI: begin
                        len_hi_d = in_data;
                        state_d  = ST_LEN_LO;
                        trunc    = in_eop;
                    end
                    ST_LEN_LO: begin
                        if (full_len != 16'd0) begin
                            len_left_d = full_len;
                            first_d    = 1'b1;
                            state_d    = ST_PAYLOAD;
                            trunc      = in_eop;
                        end else begin
                            message_en_d = 1'b1;
                            msgs_left_d  = msgs_left_q - 16'd1;
                            if (last_msg) begin
                                state_d = in_eop ? ST_IDLE : ST_DROP;
                            end else begin
                                state_d = ST_LEN_HI;
                                trunc   = in_eop;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        msg_valid_d = 1'b1;
                        msg_data_d  = in_data;
                        msg_sop_d   = first_q;
                        first_d     = 1'b0;
                        len_left_d  = len_left_q - 16'd1;
                        if (last_byte) begin
                            msg_eop_d    = 1'b1;
                            message_en_d = 1'b1;
                            msgs_left_d  = msgs_left_q - 16'd1;
                            if (last_msg) begin
                                state_d = in_eop ? ST_IDLE : ST_DROP;
                            end else begin
                                state_d = ST_LEN_HI;
                                trunc   = in_eop;
                            end
                        end else if (in_eop) begin
                            // Short message: close it for downstream, but it never counts.
                            msg_eop_d = 1'b1;
                            trunc     = 1'b1;
                        end
                    end
                    ST_DROP: begin
                        if (in_eop) begin
                            state_d = ST_IDLE;
                        end else if (!trail_err_q) begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_TRAIL;
                            trail_err_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase

                if (trunc) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TRUNC;
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            seq_sh_q     <= '0;
            cnt_sh_q     <= '0;
            msgs_left_q  <= '0;
            len_left_q   <= '0;
            len_hi_q     <= '0;
            first_q      <= 1'b0;
            trail_err_q  <= 1'b0;
            msg_valid_q  <= 1'b0;
            msg_data_q   <= '0;
            msg_sop_q    <= 1'b0;
            msg_eop_q    <= 1'b0;
            message_en_q <= 1'b0;
            hdr_valid_q  <= 1'b0;
            hdr_seq_q    <= '0;
            hdr_cnt_q    <= '0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seq_sh_q     <= seq_sh_d;
            cnt_sh_q     <= cnt_sh_d;
            msgs_left_q  <= msgs_left_d;
            len_left_q   <= len_left_d;
            len_hi_q     <= len_hi_d;
            first_q      <= first_d;
            trail_err_q  <= trail_err_d;
            msg_valid_q  <= msg_valid_d;
            msg_data_q   <= msg_data_d;
            msg_sop_q    <= msg_sop_d;
            msg_eop_q    <= msg_eop_d;
            message_en_q <= message_en_d;
            hdr_valid_q  <= hdr_valid_d;
            hdr_seq_q    <= hdr_seq_d;
            hdr_cnt_q    <= hdr_cnt_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
        end
    end

    assign msg_valid     = msg_valid_q;
    assign msg_data      = msg_data_q;
    assign msg_sop       = msg_sop_q;
    assign msg_eop       = msg_eop_q;
    assign message_en    = message_en_q;
    assign hdr_valid     = hdr_valid_q;
    assign hdr_seq_num   = hdr_seq_q;
    assign hdr_msg_count = hdr_cnt_q;
    assign err_pulse     = err_pulse_q;
    assign err_code      = err_code_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_stage2_message_framer.sv
// Directed packets drive the framer; a monitor pops expected output events whenever
// the framer presents any strobe and compares them field by field.
module tb_stage2_message_framer;
    import stage2_message_framer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_sop;
    logic        in_eop;
    logic        msg_valid;
    logic [7:0]  msg_data;
    logic        msg_sop;
    logic        msg_eop;
    logic        message_en;
    logic        hdr_valid;
    logic [63:0] hdr_seq_num;
    logic [15:0] hdr_msg_count;
    logic        err_pulse;
    logic [1:0]  err_code;
    fsm_state_e  dbg_state;

    // Event word: valid, sop, eop, message_en, hdr_valid, err_pulse, err_code[1:0], data[7:0]
    logic [15:0] exp_q[$];
    logic [79:0] hdr_q[$];
    int          checks;
    int          errors;

    stage2_message_framer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_sop        (in_sop),
        .in_eop        (in_eop),
        .msg_valid     (msg_valid),
        .msg_data      (msg_data),
        .msg_sop       (msg_sop),
        .msg_eop       (msg_eop),
        .message_en    (message_en),
        .hdr_valid     (hdr_valid),
        .hdr_seq_num   (hdr_seq_num),
        .hdr_msg_count (hdr_msg_count),
        .err_pulse     (err_pulse),
        .err_code      (err_code),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [15:0] ev(input logic v, input logic s, input logic e,
                                       input logic en, input logic h, input logic er,
                                       input logic [1:0] code, input logic [7:0] d);
        return {v, s, e, en, h, er, code, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [7:0] d, input logic s, input logic e);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'h00;
            in_sop   = 1'b0;
            in_eop   = 1'b0;
        end
    endtask

    task automatic send_header(input logic [63:0] seq, input logic [15:0] cnt, input logic eop_last);
        for (int i = 0; i < 10; i++) drive(8'(8'h50 + i), i == 0, 1'b0);
        for (int i = 7; i >= 0; i--) drive(seq[i*8 +: 8], 1'b0, 1'b0);
        drive(cnt[15:8], 1'b0, 1'b0);
        drive(cnt[7:0], 1'b0, eop_last);
    endtask

    task automatic send_len(input logic [15:0] len, input logic eop_last);
        drive(len[15:8], 1'b0, 1'b0);
        drive(len[7:0], 1'b0, eop_last);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_outs"},
              64'({msg_valid, msg_data, msg_sop, msg_eop, message_en, hdr_valid, err_pulse, err_code}),
              64'd0);
        check({name, "_seq"}, hdr_seq_num, 64'd0);
        check({name, "_cnt"}, 64'(hdr_msg_count), 64'd0);
        check({name, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [15:0] act;
        logic [15:0] exp;
        logic [79:0] hexp;
        forever begin
            @(negedge clk);
            if (rst_n && (msg_valid || msg_sop || msg_eop || message_en || hdr_valid || err_pulse)) begin
                act = {msg_valid, msg_sop, msg_eop, message_en, hdr_valid, err_pulse,
                       err_pulse ? err_code : 2'b00, msg_valid ? msg_data : 8'h00};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got %h expected none", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL event: got %h expected %h", act, exp);
                    end
                end
                if (hdr_valid) begin
                    checks++;
                    if (hdr_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_header: got %h expected none", {hdr_seq_num, hdr_msg_count});
                    end else begin
                        hexp = hdr_q.pop_front();
                        if ({hdr_seq_num, hdr_msg_count} !== hexp) begin
                            errors++;
                            $display("FAIL header: got %h expected %h", {hdr_seq_num, hdr_msg_count}, hexp);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("reset");

        // Stray bytes before any sop are ignored.
        drive(8'hAB, 1'b0, 1'b0);
        drive(8'hCD, 1'b0, 1'b1);

        // Test 1: normal packet, seq 5, two messages (3 bytes, 1 byte), with idle gaps.
        hdr_q.push_back({64'd5, 16'd2});
        exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 2'd0, 8'h00));
        exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 2'd0, 8'hAA));
        exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 2'd0, 8'hBB));
        exp_q.push_back(ev(1, 0, 1, 1, 0, 0, 2'd0, 8'hCC));
        exp_q.push_back(ev(1, 1, 1, 1, 0, 0, 2'd0, 8'hDD));
        send_header(64'd5, 16'd2, 1'b0);
        send_len(16'd3, 1'b0);
        drive(8'hAA, 1'b0, 1'b0);
        idle(2);
        drive(8'hBB, 1'b0, 1'b0);
        drive(8'hCC, 1'b0, 1'b0);
        idle(1);
        send_len(16'd1, 1'b0);
        drive(8'hDD, 1'b0, 1'b1);
        idle(3);
        check("t1_state", 64'(dbg_state), 64'(ST_IDLE));

        // Test 2: heartbeat, count 0 with eop on the last count byte.
        hdr_q.push_back({64'h1122_3344_5566_7788, 16'd0});
        exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 2'd0, 8'h00));
        send_header(64'h1122_3344_5566_7788, 16'd0, 1'b1);
        idle(3);
        check("t2_state", 64'(dbg_state), 64'(ST_IDLE));
        check("t2_seq_held", hdr_seq_num, 64'h1122_3344_5566_7788);

        // Test 3: truncation, length 4 with eop on payload byte 2.
        hdr_q.push_back({64'd3, 16'd1});
        exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 2'd0, 8'h00));
        exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 2'd0, 8'h10));
        exp_q.push_back(ev(1, 0, 1, 0, 0, 1, 2'd1, 8'h11));
        send_header(64'd3, 16'd1, 1'b0);
        send_len(16'd4, 1'b0);
        drive(8'h10, 1'b0, 1'b0);
        drive(8'h11, 1'b0, 1'b1);
        idle(3);
        check("t3_state", 64'(dbg_state), 64'(ST_IDLE));

        // Test 4: two zero-length messages, then three trailing bytes (eop on the third).
        hdr_q.push_back({64'd4, 16'd2});
        exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 2'd0, 8'h00));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 0, 2'd0, 8'h00));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 0, 2'd0, 8'h00));
        exp_q.push_back(ev(0, 0, 0, 0, 0, 1, 2'd2, 8'h00));
        send_header(64'd4, 16'd2, 1'b0);
        send_len(16'd0, 1'b0);
        send_len(16'd0, 1'b0);
        drive(8'hE0, 1'b0, 1'b0);
        drive(8'hE1, 1'b0, 1'b0);
        drive(8'hE2, 1'b0, 1'b1);
        idle(3);

        // Test 5: sop mid-payload, then a valid packet with seq 9.
        hdr_q.push_back({64'd7, 16'd1});
        exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 2'd0, 8'h00));
        exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 2'd0, 8'h20));
        exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 2'd0, 8'h21));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 1, 2'd3, 8'h00));
        hdr_q.push_back({64'd9, 16'd1});
        exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 2'd0, 8'h00));
        exp_q.push_back(ev(1, 1, 1, 1, 0, 0, 2'd0, 8'h30));
        send_header(64'd7, 16'd1, 1'b0);
        send_len(16'd5, 1'b0);
        drive(8'h20, 1'b0, 1'b0);
        drive(8'h21, 1'b0, 1'b0);
        send_header(64'd9, 16'd1, 1'b0);
        send_len(16'd1, 1'b0);
        drive(8'h30, 1'b0, 1'b1);
        idle(3);
        check("t5_seq", hdr_seq_num, 64'd9);

        // Count 0xFFFF behaves as zero messages: header only, no error.
        hdr_q.push_back({64'hFFFF_0000_0000_0001, 16'hFFFF});
        exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 2'd0, 8'h00));
        send_header(64'hFFFF_0000_0000_0001, 16'hFFFF, 1'b1);
        idle(3);
        check("ffff_state", 64'(dbg_state), 64'(ST_IDLE));

        // Last message is zero-length and ends on the eop byte: no error.
        hdr_q.push_back({64'hB, 16'd1});
        exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 2'd0, 8'h00));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 0, 2'd0, 8'h00));
        send_header(64'hB, 16'd1, 1'b0);
        send_len(16'd0, 1'b1);
        idle(3);

        // Test 6: reset mid-SEQ, then non-sop bytes must be ignored.
        for (int i = 0; i < 10; i++) drive(8'(8'h60 + i), i == 0, 1'b0);
        for (int i = 0; i < 3; i++) drive(8'(8'h70 + i), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(8'(8'h80 + i), 1'b0, 1'b0);
        drive(8'h85, 1'b0, 1'b1);
        idle(2);
        check_quiet("t6");

        // Recovery after reset.
        hdr_q.push_back({64'hA, 16'd1});
        exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 2'd0, 8'h00));
        exp_q.push_back(ev(1, 1, 1, 1, 0, 0, 2'd0, 8'h55));
        send_header(64'hA, 16'd1, 1'b0);
        send_len(16'd1, 1'b0);
        drive(8'h55, 1'b0, 1'b1);
        idle(2);

        budget = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("drain_events", 64'(exp_q.size()), 64'd0);
        check("drain_headers", 64'(hdr_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
